// File: rtl/control_divisor_pkg.sv
// Shared definitions for the restoring-divider control unit: FSM state
// encodings and the step-counter width helper.
package control_divisor_pkg;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        CARGA    = 3'd1,
        DESPLAZA = 3'd2,
        RESTA    = 3'd3,
        FIN      = 3'd4,
        ERROR    = 3'd5
    } estado_t;

    // Counter must hold tamData (N-1); width is $clog2(N) with a floor of 1.
    function automatic int cont_ancho(input int tam);
        int w;
        w = $clog2(tam + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/control_divisor_contador_pasos.sv
// Iteration down-counter: loads the step count, decrements once per
// trial subtraction and flags the final step.
module contador_pasos #(
    parameter int ANCHO = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic             dec,
    input  logic [ANCHO-1:0] valor,
    output logic [ANCHO-1:0] cuenta,
    output logic             cero
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cuenta <= '0;
        else if (carga)
            cuenta <= valor;
        else if (dec && cuenta != '0)
            cuenta <= cuenta - 1'b1;
    end

    assign cero = (cuenta == '0);

endmodule

// File: rtl/control_divisor.sv
// Control FSM of the sequential restoring divider: steers the remainder
// selector (sel0..sel4), strobes quotient bits and runs inicio/listo.
module control_divisor
    import control_divisor_pkg::*;
#(
    parameter int tamData = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic inicio,
    input  logic divisor_cero,
    input  logic neg,
    output logic sel0,
    output logic sel1,
    output logic sel2,
    output logic sel3,
    output logic sel4,
    output logic carga_cociente,
    output logic bit_cociente,
    output logic ocupado,
    output logic listo,
    output logic error_div0
);

    localparam int CW = cont_ancho(tamData);

    estado_t       state;
    logic [CW-1:0] cont;
    logic          cont_cero;

    contador_pasos #(.ANCHO(CW)) u_cont (
        .clk    (clk),
        .reset  (reset),
        .carga  (state == CARGA),
        .dec    (state == RESTA),
        .valor  (CW'(tamData)),
        .cuenta (cont),
        .cero   (cont_cero)
    );

    // FIN also accepts a new request so a held inicio runs back-to-back
    // without an idle cycle in between.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= REPOSO;
        end else begin
            case (state)
                REPOSO, FIN: begin
                    if (inicio)
                        state <= divisor_cero ? ERROR : CARGA;
                    else
                        state <= REPOSO;
                end
                CARGA:    state <= DESPLAZA;
                DESPLAZA: state <= RESTA;
                RESTA:    state <= cont_cero ? FIN : DESPLAZA;
                ERROR:    state <= REPOSO;
                default:  state <= REPOSO;
            endcase
        end
    end

    always_comb begin
        sel0           = 1'b0;
        sel1           = 1'b0;
        sel2           = 1'b0;
        sel3           = 1'b0;
        sel4           = 1'b0;
        carga_cociente = 1'b0;
        bit_cociente   = 1'b0;
        ocupado        = 1'b0;
        listo          = 1'b0;
        error_div0     = 1'b0;
        case (state)
            CARGA: begin
                sel1    = 1'b1;
                ocupado = 1'b1;
            end
            DESPLAZA: begin
                sel2    = 1'b1;
                ocupado = 1'b1;
            end
            RESTA: begin
                // A negative trial restores by simply holding the remainder.
                sel3           = ~neg;
                sel0           = neg;
                carga_cociente = 1'b1;
                bit_cociente   = ~neg;
                ocupado        = 1'b1;
            end
            FIN: begin
                sel0    = 1'b1;
                ocupado = 1'b1;
                listo   = 1'b1;
            end
            ERROR: begin
                sel4       = 1'b1;
                error_div0 = 1'b1;
            end
            default: sel0 = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_control_divisor.sv
// Bench for control_divisor: an 8-bit restoring datapath driven by the
// select lines, checked against plain integer division.
module tb_control_divisor;
    import control_divisor_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inicio = 1'b0;
    logic divisor_cero;
    logic neg;
    logic sel0, sel1, sel2, sel3, sel4;
    logic carga_cociente, bit_cociente, ocupado, listo, error_div0;

    int n_checks = 0;
    int n_fail = 0;
    int onehot_bad = 0;

    logic [7:0] dd_in = 8'd0;
    logic [7:0] dv = 8'd1;
    logic [8:0] resto = 9'd0;
    logic [7:0] dvd = 8'd0;
    logic [7:0] q = 8'd0;

    always #5 clk = ~clk;

    control_divisor #(.tamData(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .inicio         (inicio),
        .divisor_cero   (divisor_cero),
        .neg            (neg),
        .sel0           (sel0),
        .sel1           (sel1),
        .sel2           (sel2),
        .sel3           (sel3),
        .sel4           (sel4),
        .carga_cociente (carga_cociente),
        .bit_cociente   (bit_cociente),
        .ocupado        (ocupado),
        .listo          (listo),
        .error_div0     (error_div0)
    );

    assign divisor_cero = (dv == 8'd0);
    assign neg = (resto < {1'b0, dv});

    always @(posedge clk) begin
        if (sel1) begin
            resto <= 9'd0;
            dvd   <= dd_in;
        end else if (sel2) begin
            resto <= {resto[7:0], dvd[7]};
            dvd   <= {dvd[6:0], 1'b0};
        end else if (sel3) begin
            resto <= resto - {1'b0, dv};
        end else if (sel4) begin
            resto <= 9'd0;
        end
        if (carga_cociente)
            q <= {q[6:0], bit_cociente};
    end

    always @(negedge clk) begin
        if (int'(sel0) + int'(sel1) + int'(sel2) + int'(sel3) + int'(sel4) != 1) begin
            onehot_bad++;
            $display("FAIL onehot sel=%b%b%b%b%b at %0t", sel4, sel3, sel2, sel1, sel0, $time);
        end
    end

    // Launches one division; cycle k counts from the cycle the request is sampled.
    task automatic do_div(input logic [7:0] a, input logic [7:0] b, input int pulse_at,
                          input logic hold, output int lat, output int strobes, output int n_sel3);
        dd_in = a;
        dv = b;
        lat = -1;
        strobes = 0;
        n_sel3 = 0;
        @(posedge clk); #1 inicio = 1'b1;
        @(posedge clk); #1 inicio = hold;
        for (int k = 1; k <= 40; k++) begin
            if (pulse_at != 0 && k == pulse_at) inicio = 1'b1;
            else if (pulse_at != 0 && k == pulse_at + 1) inicio = hold;
            @(negedge clk);
            if (carga_cociente) begin
                strobes++;
                if (sel3) n_sel3++;
            end
            if (listo) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_div(input string nm, input logic [7:0] a, input logic [7:0] b,
                             input int lat, input int strobes);
        n_checks++;
        if (lat !== 18) begin n_fail++; $display("FAIL %s latency got %0d want 18", nm, lat); end
        n_checks++;
        if (strobes !== 8) begin n_fail++; $display("FAIL %s strobes got %0d want 8", nm, strobes); end
        n_checks++;
        if (q !== a / b) begin n_fail++; $display("FAIL %s quotient got %0d want %0d", nm, q, a / b); end
        n_checks++;
        if (resto !== {1'b0, a % b}) begin
            n_fail++; $display("FAIL %s remainder got %0d want %0d", nm, resto, a % b);
        end
    endtask

    task automatic test_reset;
        int lat, st, s3;
        @(negedge clk);
        n_checks++;
        if ({sel4, sel3, sel2, sel1, sel0, listo, ocupado, error_div0, carga_cociente} !== 9'b00001_0000) begin
            n_fail++; $display("FAIL reset_idle outputs got %b", {sel4, sel3, sel2, sel1, sel0, listo, ocupado});
        end
        @(posedge clk); #1 reset = 1'b0;
        dd_in = 8'd200; dv = 8'd3;
        @(posedge clk); #1 inicio = 1'b1;
        @(posedge clk); #1 inicio = 1'b0;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({sel0, sel1, sel2, sel3, sel4, listo, ocupado} !== 7'b1000000 || dut.state !== REPOSO) begin
            n_fail++; $display("FAIL reset_midrun sel0=%b listo=%b ocupado=%b state=%0d", sel0, listo, ocupado, dut.state);
        end
        @(posedge clk); #1 reset = 1'b0;
        st = 0;
        repeat (25) begin
            @(negedge clk);
            if (listo || error_div0 || ocupado) st++;
        end
        n_checks++;
        if (st !== 0) begin n_fail++; $display("FAIL reset_quiet activity cycles got %0d want 0", st); end
        do_div(8'd1, 8'd1, 0, 1'b0, lat, st, s3);
        check_div("after_reset", 8'd1, 8'd1, lat, st);
    endtask

    task automatic test_directed;
        int lat, st, s3;
        do_div(8'd100, 8'd7, 0, 1'b0, lat, st, s3);
        check_div("100/7", 8'd100, 8'd7, lat, st);
        do_div(8'd255, 8'd1, 0, 1'b0, lat, st, s3);
        check_div("255/1", 8'd255, 8'd1, lat, st);
        n_checks++;
        if (s3 !== 8) begin n_fail++; $display("FAIL 255/1 sel3_count got %0d want 8", s3); end
        do_div(8'd5, 8'd9, 0, 1'b0, lat, st, s3);
        check_div("5/9", 8'd5, 8'd9, lat, st);
        n_checks++;
        if (s3 !== 0) begin n_fail++; $display("FAIL 5/9 sel3_count got %0d want 0", s3); end
    endtask

    task automatic test_div0;
        int bad;
        dd_in = 8'd77; dv = 8'd0;
        @(posedge clk); #1 inicio = 1'b1;
        @(posedge clk); #1 inicio = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({error_div0, sel4, ocupado, listo} !== 4'b1100) begin
            n_fail++; $display("FAIL div0_t1 err/sel4/ocupado/listo got %b want 1100", {error_div0, sel4, ocupado, listo});
        end
        @(negedge clk);
        n_checks++;
        if ({error_div0, sel0, ocupado} !== 3'b010 || dut.state !== REPOSO) begin
            n_fail++; $display("FAIL div0_t2 err/sel0/ocupado got %b state %0d", {error_div0, sel0, ocupado}, dut.state);
        end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (listo || ocupado || error_div0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL div0_quiet activity cycles got %0d want 0", bad); end
        dv = 8'd1;
    endtask

    task automatic test_ignored_inicio;
        int lat, st, s3;
        do_div(8'd100, 8'd7, 5, 1'b0, lat, st, s3);
        check_div("pulse_t5", 8'd100, 8'd7, lat, st);
        @(negedge clk);
        n_checks++;
        if (ocupado !== 1'b0 || dut.state !== REPOSO) begin
            n_fail++; $display("FAIL pulse_t5 requeued ocupado=%b state=%0d want idle", ocupado, dut.state);
        end
    endtask

    task automatic test_back_to_back;
        int lat, st, s3, k2;
        do_div(8'd201, 8'd13, 0, 1'b1, lat, st, s3);
        check_div("b2b_first", 8'd201, 8'd13, lat, st);
        @(negedge clk);
        n_checks++;
        if ({sel1, ocupado} !== 2'b11 || dut.state !== CARGA) begin
            n_fail++; $display("FAIL b2b_carga sel1/ocupado got %b state %0d want CARGA", {sel1, ocupado}, dut.state);
        end
        inicio = 1'b0;
        k2 = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (listo) begin k2 = k; break; end
        end
        n_checks++;
        if (k2 !== 18) begin n_fail++; $display("FAIL b2b_second latency got %0d want 18", k2); end
        n_checks++;
        if (q !== 8'd15 || resto !== 9'd6) begin
            n_fail++; $display("FAIL b2b_second q/r got %0d/%0d want 15/6", q, resto);
        end
    endtask

    task automatic test_random;
        int lat, st, s3;
        logic [7:0] a, b;
        for (int i = 0; i < 15; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            do_div(a, b, 0, 1'b0, lat, st, s3);
            check_div("random", a, b, lat, st);
        end
    endtask

    task automatic test_onehot;
        n_checks++;
        if (onehot_bad !== 0) begin n_fail++; $display("FAIL onehot_total bad cycles got %0d want 0", onehot_bad); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div0();
        test_ignored_inicio();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        test_onehot();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
